// File: rtl/ram_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_stream
// Purpose  : Burst read sequencer for one RAM port; credit-bounded reads feed a
//            return FIFO that is presented as a valid/ready stream with last.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rd_stream #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_dout_valid,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]         C_DEPTH    = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]       C_FULL     = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]       C_ONE_C    = CW'(1);
    localparam logic [PW-1:0]       C_LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0]       C_ONE_P    = PW'(1);
    localparam logic [ADDR_WIDTH:0] C_ONE_W    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_ONE_A  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH:0]     last_idx_q, last_idx_d;
    logic [ADDR_WIDTH:0]     issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH:0]     rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH:0]     mem_q [FIFO_DEPTH];

    logic                    w_credit;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_rx_last;
    logic [DATA_WIDTH:0]     w_head;

    // Credit uses registered occupancy only, so m_ready never reaches ram_en.
    assign w_credit  = ({1'b0, inflight_q} + {1'b0, cnt_q}) < C_DEPTH;
    assign w_issue   = (state_q == S_ISSUE) && w_credit;
    assign w_push    = ram_dout_valid && (inflight_q != '0);
    assign w_pop     = m_valid && m_ready;
    assign w_rx_last = (rx_cnt_q == last_idx_q);
    assign w_head    = mem_q[rd_ptr_q];

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign ram_en    = w_issue;
    assign ram_we    = 1'b0;
    assign ram_din   = '0;
    assign ram_addr  = base_q + issue_cnt_q[ADDR_WIDTH-1:0];
    assign m_valid   = (cnt_q != '0);
    assign m_data    = w_head[DATA_WIDTH-1:0];
    assign m_last    = w_head[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        last_idx_d  = last_idx_q;
        issue_cnt_d = issue_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        if (w_push) begin
            rx_cnt_d = rx_cnt_q + C_ONE_W;
        end
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && (cmd_len != '0)) begin
                    state_d     = S_ISSUE;
                    base_d      = cmd_addr;
                    last_idx_d  = {1'b0, cmd_len - C_ONE_A};
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                end
            end
            S_ISSUE: begin
                if (w_issue) begin
                    issue_cnt_d = issue_cnt_q + C_ONE_W;
                    if (issue_cnt_q == last_idx_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && m_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        cnt_d      = cnt_q;
        case ({w_issue, w_push})
            2'b10:   inflight_d = inflight_q + C_ONE_C;
            2'b01:   inflight_d = inflight_q - C_ONE_C;
            default: inflight_d = inflight_q;
        endcase
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + C_ONE_C;
            2'b01:   cnt_d = cnt_q - C_ONE_C;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            last_idx_q  <= '0;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
            inflight_q  <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            base_q      <= base_d;
            last_idx_q  <= last_idx_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            inflight_q  <= inflight_d;
            cnt_q       <= cnt_d;
            if (w_push) begin
                mem_q[wr_ptr_q] <= {w_rx_last, ram_dout};
                wr_ptr_q        <= (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + C_ONE_P;
            end
            if (w_pop) begin
                rd_ptr_q <= (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + C_ONE_P;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (cnt_q == C_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_ram_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rd_stream
// Purpose  : Self-checking bench for ram_rd_stream with a 2-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rd_stream;

    localparam int DW = 36;
    localparam int AW = 14;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_dout_valid;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    ram_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_dout_valid(ram_dout_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM port with en->valid of two cycles; it is deliberately not reset.
    logic [DW-1:0] ram_mem [1 << AW];
    logic [DW-1:0] p1_d = '0;
    logic [DW-1:0] p2_d = '0;
    logic          p1_v = 1'b0;
    logic          p2_v = 1'b0;
    always @(posedge clk) begin
        p1_v <= ram_en;
        if (ram_en) p1_d <= ram_mem[ram_addr];
        p2_v <= p1_v;
        p2_d <= p1_d;
    end
    assign ram_dout       = p2_d;
    assign ram_dout_valid = p2_v;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] len;
        int            mode;
        int            exp_lat;
        int            exp_stall;
        int            exp_bubbles;
    } burst_t;

    beat_t  sb[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     rdy_mode = 0;
    int     rdy_phase = 0;
    bit     mon_en = 1'b0;

    logic [AW-1:0] b_base = '0;
    int     b_len = 0;
    int     b_issued = 0;
    int     b_beats = 0;
    int     b_first_valid = -1;
    int     b_prev_pop = -1;
    int     b_bubbles = 0;
    int     b_stalls = 0;
    int     hs_cyc = 0;
    int     issued_tot = 0;
    int     popped_tot = 0;
    bit     prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((rdy_phase % 3) == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            rdy_phase++;
        end
    end

    // Monitor: scoreboard pops, address sequence, credit bound, hold stability.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            int outstanding;
            logic [AW-1:0] ea;
            beat_t e;
            outstanding = issued_tot - popped_tot;
            if (outstanding > FD) chk("credit_bound", 64'(outstanding), 64'(FD));
            if (outstanding == FD) chk("ram_en_no_credit", ram_en, 0);
            if (ram_en) begin
                ea = b_base + AW'(b_issued);
                chk("ram_addr", ram_addr, ea);
                b_issued++;
                issued_tot++;
            end else if (busy && (b_issued < b_len)) begin
                b_stalls++;
            end
            if (m_valid && (b_first_valid < 0) && (b_len > 0)) b_first_valid = cyc;
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got data %0h, expected no beat", m_data);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", m_data, e.data);
                    chk("m_last", m_last, e.last);
                end
                if ((b_prev_pop >= 0) && (cyc != b_prev_pop + 1)) b_bubbles++;
                b_prev_pop = cyc;
                b_beats++;
                popped_tot++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_reset_vals();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
        int guard;
        beat_t e;
        @(posedge clk);
        #1;
        b_base = a; b_len = int'(l); b_issued = 0; b_beats = 0;
        b_first_valid = -1; b_prev_pop = -1; b_bubbles = 0; b_stalls = 0;
        cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_accept", cmd_ready, 1);
        hs_cyc = cyc;
        for (int i = 0; i < int'(l); i++) begin
            e.data = DW'(AW'(a + AW'(i)));
            e.last = (i == int'(l) - 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!((sb.size() == 0) && cmd_ready) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("done_timeout", (guard < 2000), 1);
        chk("ready_after_last", 64'(cyc), 64'(b_prev_pop + 1));
        chk("busy_after_last", busy, 0);
    endtask

    task automatic run_burst(input burst_t b);
        rdy_mode = b.mode;
        send_cmd(b.addr, b.len);
        wait_done();
        chk("beats", 64'(b_beats), 64'(b.len));
        chk("issues", 64'(b_issued), 64'(b.len));
        chk("first_valid_lat", 64'(b_first_valid - hs_cyc), 64'(b.exp_lat));
        if (b.exp_stall >= 0) chk("credit_stall", (b_stalls > 0), 64'(b.exp_stall));
        if (b.exp_bubbles >= 0) chk("bubbles", 64'(b_bubbles), 64'(b.exp_bubbles));
        chk("sb_empty", 64'(sb.size()), 0);
    endtask

    burst_t tbl [7];
    burst_t tail;

    initial begin
        // {addr, len, ready mode (0 always, 1 = 1,0,0 pattern, 2 random), lat, stall, bubbles}
        tbl[0] = '{14'h0010, 14'd4,  0, 4,  0,  0};
        tbl[1] = '{14'h0010, 14'd4,  1, 4,  0, -1};
        tbl[2] = '{14'h3FFE, 14'd4,  0, 4,  0,  0};
        tbl[3] = '{14'h0000, 14'd16, 0, 4,  0,  0};
        tbl[4] = '{14'h0100, 14'd12, 1, 4,  1, -1};
        tbl[5] = '{14'h0200, 14'd1,  0, 4,  0,  0};
        tbl[6] = '{14'h1234, 14'd9,  2, 4, -1, -1};
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = DW'(i);

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals();
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) run_burst(tbl[i]);

        rdy_mode = 0;
        send_cmd(14'h0100, 14'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("len0_cmd_ready", cmd_ready, 1);
            chk("len0_busy", busy, 0);
            chk("len0_ram_en", ram_en, 0);
            chk("len0_m_valid", m_valid, 0);
        end

        send_cmd(14'h0030, 14'd8);
        for (int g = 0; g < 50 && b_issued < 2; g++) @(negedge clk);
        chk("pre_reset_issues", (b_issued >= 2), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        issued_tot = 0; popped_tot = 0; b_len = 0; b_issued = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stale_m_valid", m_valid, 0);
            chk("stale_busy", busy, 0);
        end

        tail = '{14'h0020, 14'd2, 0, 4, 0, 0};
        run_burst(tail);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/ram_rd_stream.md
# ram_rd_stream

Read-side sequencer that sits directly downstream of a true-dual-port RAM port. It accepts a burst command (base address, word count) and issues reads on one RAM port. It captures the RAM's returned data using the port's output-valid flag and presents the words as a valid/ready stream with a last marker. Credit-based flow control bounds in-flight reads, so stream backpressure never loses RAM output, for any RAM output-pipe depth.

## Interface
- DATA_WIDTH, 36: RAM word width.
- ADDR_WIDTH, 14: RAM address width; also the width of the burst length.
- FIFO_DEPTH, 4: return-buffer entries, ≥ 2. Full throughput requires FIFO_DEPTH ≥ (RAM en→valid latency + 2).
- clk  in  1  sole clock; the RAM port clock is tied to the same net.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  command accepted when both high.
- cmd_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  ADDR_WIDTH  word count; 0 = no-op.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  constant 0.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_din  out  DATA_WIDTH  constant 0.
- ram_dout  in  DATA_WIDTH  RAM read data.
- ram_dout_valid  in  1  RAM read data valid; one pulse per enabled read.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream consumer ready.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  final word of the burst.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1. Accepting len=0 keeps the FSM in IDLE and produces no output. Accepting len>0 latches addr and len, clears counters, and moves to ISSUE.
  - ISSUE: ram_en=1 in every cycle where credit is available, with ram_addr = cmd_addr + issue_cnt (mod 2^ADDR_WIDTH, wraps silently). After issuing word len-1, move to DRAIN.
  - DRAIN: ram_en=0. Move to IDLE on the cycle the m_last beat is accepted (m_valid & m_ready & m_last).
- cmd_ready is 0 outside IDLE. There is no command queuing.
- Credit: inflight counter +1 on issue, −1 on ram_dout_valid.
  - Issue is allowed only if inflight + fifo_count < FIFO_DEPTH, using the registered values.
  - A pop in the same cycle does not grant credit until the next cycle.
- Return path:
  - Each ram_dout_valid writes {ram_dout, last} into the FIFO, with last = (rx_cnt == len-1). rx_cnt increments per return.
  - ram_dout_valid when inflight==0 is ignored. This covers stale returns after reset.
- FIFO:
  - Circular buffer of FIFO_DEPTH entries; the head drives m_data/m_last.
  - Pop on m_valid & m_ready. m_valid = (fifo_count ≠ 0).
  - Simultaneous push and pop leaves the count unchanged.
  - Overflow is impossible by credit; an assertion flags it in simulation.
- Counters are ADDR_WIDTH+1 bits where they must hold len.

## Timing
- Reset values: cmd_ready=1, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, m_valid=0, m_data=0, m_last=0, busy=0. All counters and FIFO pointers are 0.
- Reset mid-burst: the FSM returns to IDLE immediately and FIFO contents are discarded. RAM returns arriving afterwards are dropped (inflight=0).
- ram_en and ram_addr are combinational from registered state and counters. No combinational path exists from m_ready to ram_en.
- Latency with a RAM of en→valid = 2 cycles (one output pipe stage):
  - Command handshake at edge E0; ram_en high in cycle 1.
  - ram_dout_valid after E2; FIFO write at E3; m_valid high from cycle 4.
- Throughput: one word/cycle sustained with m_ready=1 and FIFO_DEPTH ≥ 4 (for this RAM).
- Back-to-back bursts: next cmd_ready rises the cycle after the last beat is accepted.
- m_data/m_last stay stable while m_valid & ~m_ready.

## Test plan
- cmd_addr=0x0010, len=4, RAM preloaded word[i]=i, m_ready=1: four beats 0x10..0x13 on consecutive cycles; m_last only on 0x13; first m_valid 4 cycles after the handshake.
- Same burst with m_ready toggling 1,0,0,1,…: data order and values unchanged, no drops or duplicates; inflight+fifo_count never exceeds 4; ram_en stalls when credit runs out.
- Wrap: cmd_addr=0x3FFE, len=4 → ram_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001; m_last on the fourth beat.
- len=0: cmd_ready stays 1, busy stays 0, no ram_en, no m_valid.
- rst_n low for 1 cycle mid-burst after 2 issues: all outputs at reset values. Trailing ram_dout_valid pulses produce no m_valid. A new burst (addr 0x0020, len=2) then completes correctly.
- len=16 with m_ready=1 and FIFO_DEPTH=4: sixteen consecutive beats with no bubble after the first; busy drops the cycle after the last beat.
